vedic_mult_pipe: RTL
====================

# vedic_mult_pipe

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier. It generalises the fixed 4-bit combinational Vedic multiplier to any power-of-two operand width, with per-operation signed/unsigned mode. It accepts one operand pair per cycle over a valid/ready handshake and returns the full-width product after a fixed latency. It is the multiply datapath for downstream DSP/MAC blocks in this codebase.

## Interface

- WIDTH, 4: operand width in bits. Legal values are 4, 8, 16, 32 (power of two, ≥4); any other value is an elaboration error.
- LATENCY (localparam), log2(WIDTH): pipeline depth in cycles.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- sgn  in  1  1 = two's-complement operands and result; 0 = unsigned.
- out_valid  out  1  p holds a valid product.
- out_ready  in  1  consumer takes p this cycle.
- p  out  2*WIDTH  product.

## Operation

- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Pipeline enable: adv = !out_valid | out_ready. in_ready = adv & !rst. All stages, including bubbles, shift together when adv=1 and hold when adv=0. Bubbles are not collapsed.
- Each stage carries a valid bit and a sign-fix bit alongside its data.
- Stage 0 (input register):
  - Unsigned mode: magnitudes are a and b.
  - Signed mode: magnitudes are |a| and |b|, computed as WIDTH-bit unsigned values. The most negative value maps to 2^(WIDTH-1), which fits.
  - neg = sgn & (a[MSB] ^ b[MSB]).
  - Then all 2x2 Vedic partial products are formed (crosswise: p0=a0b0, p1=a1b0^a0b1 with carry, p2/p3 from a1b1 plus carry) and registered.
- Stages 1..LATENCY-1 each register one recursive combine level. Four N/2×N/2 products (LL, LH, HL, HH) form the N×N product: LL + ((LH+HL) << N/2) + (HH << N). Adders are exact, with no truncation inside any level.
- Final stage: if neg, p = two's-complement negation of the unsigned 2*WIDTH result; else p = result. p is registered.
- Width rules: p is exact for all inputs in both modes. No overflow is possible. Signed range is −2^(2W−2)+2^(W−1) .. 2^(2W−2).
- sgn is sampled per transfer. Mixed-mode back-to-back operations are legal.

## Timing

- Reset (async assert, synchronous-release assumed upstream): all stage valid bits = 0, out_valid = 0, p = 0, in_ready = 0 while rst=1, in_ready = 1 on the first cycle after release.
- Latency: a pair accepted at edge k appears with out_valid=1 after edge k+LATENCY, provided adv stays 1 throughout. This is 2 cycles for WIDTH=4 and 3 for WIDTH=8. Each cycle with adv=0 adds one cycle.
- Throughput: 1 result/cycle with out_ready held 1.
- Backpressure: out_valid=1 & out_ready=0 drives in_ready to 0 in the same cycle. p and out_valid are then held stable until taken. No data is lost or duplicated.
- Simultaneous output take and input accept in the same cycle is legal at full rate.
- in_valid=0 with adv=1 inserts a bubble, which emerges as out_valid=0 LATENCY cycles later.
- Reset mid-operation: all in-flight operations are discarded, and no out_valid pulse follows reset release.
- a, b, sgn are don't-care when in_valid=0. Their X values must not propagate to out_valid.

## Test plan

- WIDTH=4, unsigned, out_ready=1: (0,1), (1,2), (10,10), (15,15) on consecutive cycles -> p = 8'h00, 8'h02, 8'h64, 8'hE1 on 4 consecutive cycles, starting 2 cycles after the first accept.
- WIDTH=4, sgn=1: (−8,−8) -> 8'h40; (−1,7) -> 8'hF9; (−8,7) -> 8'hC8; (7,7) -> 8'h31.
- WIDTH=8: unsigned (255,255) -> 16'hFE01 after 3 cycles; signed (−128,127) -> 16'hC080; signed (−128,−128) -> 16'h4000.
- Backpressure: stream 6 ops with out_ready toggling 1,0,0,1,... -> in_ready low exactly when out_valid&!out_ready; all 6 products are delivered in order, each exactly once, with p stable while stalled.
- Reset mid-stream: assert rst asynchronously with 2 ops in flight -> out_valid=0 and p=0 immediately; no product appears after release; the next op returns a correct result.
- Random: 10k random (a,b,sgn) per WIDTH∈{4,8,16} with random in_valid/out_ready -> every p matches a reference model, in order.

Source files
------------

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined Urdhva-Tiryagbhyam (Vedic) multiplier.
//
// A WIDTH x WIDTH product is built from 2x2 Vedic cells. Each later pipeline
// level merges four half-size products into one product of twice the size.
// Signed operands are multiplied as magnitudes, and the sign is reapplied in
// the last stage.
//
// Parameter:
//   WIDTH      operand width (4, 8, 16 or 32); latency is log2(WIDTH) cycles
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair present
//   in_ready   pair is accepted this cycle
//   a, b       operands (WIDTH bits)
//   sgn        1 = two's-complement operands and product, 0 = unsigned
//   out_valid  p holds a product
//   out_ready  consumer takes p this cycle
//   p          product (2*WIDTH bits)
module vedic_mult_pipe #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sgn,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p
);

   localparam int LATENCY = $clog2(WIDTH);
   localparam int HALF    = WIDTH / 2;

   if (WIDTH != 4 && WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
      $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
   end

   // All product levels are packed into one vector. Level s holds products of
   // 2^(s+1)-bit operands, and it occupies WIDTH^2 >> s bits. The offsets form
   // a geometric series.
   function automatic int lvl_off(input int s);
      return 2 * WIDTH * WIDTH - ((2 * WIDTH * WIDTH) >> s);
   endfunction

   localparam int TOTAL = lvl_off(LATENCY);

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
      // The most negative value negates to itself, and that pattern reads
      // correctly as the unsigned value 2^(WIDTH-1).
      return (s & v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
      logic c1;
      logic t;
      c1 = x[1] & y[0] & x[0] & y[1];
      t  = x[1] & y[1];
      return {t & c1, t ^ c1, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
   endfunction

   function automatic logic [2*WIDTH-1:0] sign_fix(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic                 adv;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic                 neg_d;
   logic [TOTAL-1:0]     pp_d, pp_q;
   logic [2*WIDTH-1:0]   prod;
   logic [LATENCY-1:0]   vld_q, neg_q;
   logic                 out_valid_q;
   logic [2*WIDTH-1:0]   p_q;

   // Every stage, bubbles included, moves only when the output is free or is
   // being taken.
   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv & ~rst;

   // ---- stage 0: operand magnitudes and 2x2 crosswise products ----
   assign mag_a = magnitude(a, sgn);
   assign mag_b = magnitude(b, sgn);
   assign neg_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);

   for (genvar i = 0; i < HALF; i++) begin : g_leaf_row
      for (genvar j = 0; j < HALF; j++) begin : g_leaf_col
         assign pp_d[(i*HALF+j)*4 +: 4] = vedic2x2(mag_a[2*i +: 2], mag_b[2*j +: 2]);
      end
   end

   // ---- stages 1..LATENCY-1: each merges four half-size products ----
   for (genvar s = 1; s < LATENCY; s++) begin : g_lvl
      localparam int N    = 2 << s;       // operand width of products formed here
      localparam int M    = WIDTH / N;    // products per operand dimension
      localparam int OFF  = lvl_off(s);
      localparam int PREV = lvl_off(s - 1);
      for (genvar i = 0; i < M; i++) begin : g_row
         for (genvar j = 0; j < M; j++) begin : g_col
            logic [2*N-1:0] ll, lh, hl, hh;
            // Chunk i of this level is made of sub-chunks 2i (low) and 2i+1 (high).
            assign ll = {{N{1'b0}}, pp_q[PREV + ((2*i)  *(2*M) + 2*j  )*N +: N]};
            assign lh = {{N{1'b0}}, pp_q[PREV + ((2*i)  *(2*M) + 2*j+1)*N +: N]};
            assign hl = {{N{1'b0}}, pp_q[PREV + ((2*i+1)*(2*M) + 2*j  )*N +: N]};
            assign hh = {{N{1'b0}}, pp_q[PREV + ((2*i+1)*(2*M) + 2*j+1)*N +: N]};
            assign pp_d[OFF + (i*M+j)*2*N +: 2*N] = ll + ((lh + hl) << (N/2)) + (hh << N);
         end
      end
   end

   assign prod = pp_q[lvl_off(LATENCY-1) +: 2*WIDTH];

   always_ff @(posedge clk) begin
      if (adv) begin
         pp_q <= pp_d;
      end
   end

   // ---- final stage: reapply sign, register product ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         neg_q       <= '0;
         out_valid_q <= 1'b0;
         p_q         <= '0;
      end else if (adv) begin
         vld_q       <= {vld_q[LATENCY-2:0], in_valid};
         neg_q       <= {neg_q[LATENCY-2:0], neg_d};
         out_valid_q <= vld_q[LATENCY-1];
         p_q         <= sign_fix(prod, neg_q[LATENCY-1]);
      end
   end

   assign out_valid = out_valid_q;
   assign p         = p_q;

endmodule
